// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin scheduler over N source FIFOs with burst limit
module fifo_rr_scheduler #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         fifo_empty,
    input  logic [N*DW-1:0]      fifo_data,
    output logic [N-1:0]         fifo_pop,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_port,
    input  logic                 out_ready
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] out_port_q, out_port_d;
    logic [PW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          load_en;
    logic          any_ne;
    logic          burst_active;
    logic          grant;
    logic          scan_found;
    logic [PW-1:0] scan_idx;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Scan order starts just after last and wraps so that last itself is visited last.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        sum        = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last_q} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            if (!scan_found && !fifo_empty[sum[PW-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        load_en      = !out_valid_q || out_ready;
        any_ne       = !(&fifo_empty);
        burst_active = (cnt_q != '0) && (cnt_q < CW'(BURST));
        cand         = (burst_active && !fifo_empty[last_q]) ? last_q : scan_idx;
        grant        = !rst && load_en && any_ne;

        fifo_pop    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        if (grant) begin
            fifo_pop[cand] = 1'b1;
            out_valid_d    = 1'b1;
            out_data_d     = fifo_data[int'(cand)*DW +: DW];
            out_port_d     = cand;
            if (cand == last_q && burst_active) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                last_d = cand;
                cnt_d  = CW'(1);
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // last = N-1 after reset so the first scan begins at port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            last_q      <= PW'(N - 1);
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - scoreboard bench for fifo_rr_scheduler (BURST=4 and BURST=1)
module tb_fifo_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 2;

    typedef struct packed {
        logic [PW-1:0] port;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_ready = 1'b1;

    logic [N-1:0]    a_empty, a_pop, b_empty, b_pop;
    logic [N*DW-1:0] a_data, b_data;
    logic            a_valid, b_valid;
    logic [DW-1:0]   a_odata, b_odata;
    logic [PW-1:0]   a_oport, b_oport;

    logic [DW-1:0] qa [N][$];
    logic [DW-1:0] qb [N][$];
    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks  = 0;
    int passed  = 0;
    int pop_err = 0;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(.N(N), .DW(DW), .BURST(4)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_data(a_data), .fifo_pop(a_pop),
        .out_valid(a_valid), .out_data(a_odata), .out_port(a_oport), .out_ready(out_ready)
    );

    fifo_rr_scheduler #(.N(N), .DW(DW), .BURST(1)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_data(b_data), .fifo_pop(b_pop),
        .out_valid(b_valid), .out_data(b_odata), .out_port(b_oport), .out_ready(out_ready)
    );

    function automatic logic [DW-1:0] wd(input int p, input int k);
        return 32'hA000_0000 | (32'(p) << 16) | 32'(k);
    endfunction

    function automatic exp_t mk(input int p, input int k);
        exp_t e;
        e.port = PW'(p);
        e.data = wd(p, k);
        return e;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            a_empty[i] = (qa[i].size() == 0);
            a_data[i*DW +: DW] = a_empty[i] ? '0 : qa[i][0];
            b_empty[i] = (qb[i].size() == 0);
            b_data[i*DW +: DW] = b_empty[i] ? '0 : qb[i][0];
        end
    endtask

    // One clock: sample pops just before the edge, retire them from the models after it.
    task automatic tick();
        logic [N-1:0] pa, pb;
        #1;
        pa = a_pop;
        pb = b_pop;
        @(posedge clk);
        #1;
        if ($countones(pa) > 1 || $countones(pb) > 1) pop_err++;
        for (int i = 0; i < N; i++) begin
            if (pa[i]) begin
                if (qa[i].size() == 0) pop_err++;
                else void'(qa[i].pop_front());
            end
            if (pb[i]) begin
                if (qb[i].size() == 0) pop_err++;
                else void'(qb[i].pop_front());
            end
        end
        refresh();
        #1;
    endtask

    task automatic load_a(input int p, input int n);
        for (int k = 0; k < n; k++) qa[p].push_back(wd(p, k));
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        qa[0].push_back(wd(0, 99));
        qb[1].push_back(wd(1, 99));
        refresh();
        tick();
        tick();
        checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_valid); else passed++;
        checks++; if (a_odata !== '0) $display("FAIL reset_data: got %h expected 0", a_odata); else passed++;
        checks++; if (a_oport !== '0) $display("FAIL reset_port: got %0d expected 0", a_oport); else passed++;
        checks++; if (a_pop !== '0 || b_pop !== '0) $display("FAIL reset_pop: got %b/%b expected 0/0", a_pop, b_pop); else passed++;
        checks++; if (qa[0].size() != 1 || qb[1].size() != 1) $display("FAIL reset_no_pop: sizes %0d/%0d expected 1/1", qa[0].size(), qb[1].size()); else passed++;
        qa[0].delete();
        qb[1].delete();
        refresh();
        rst = 1'b0;
        tick();
        checks++; if (b_valid !== 1'b0) $display("FAIL reset_idle_b: got %b expected 0", b_valid); else passed++;
    endtask

    task automatic test_burst();
        exp_t e;
        int budget = 0;
        int gaps = 0;
        bit seen = 0;
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) load_a(p, 8);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                for (int k = 0; k < 4; k++) exp_a.push_back(mk(p, r*4 + k));
        while (exp_a.size() > 0 && budget < 60) begin
            tick();
            budget++;
            if (a_valid) begin
                seen = 1;
                e = exp_a.pop_front();
                checks++;
                if (a_oport !== e.port || a_odata !== e.data)
                    $display("FAIL burst_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
                else passed++;
            end else if (seen) gaps++;
        end
        checks++; if (exp_a.size() != 0) $display("FAIL burst_timeout: %0d words left expected 0", exp_a.size()); else passed++;
        checks++; if (gaps != 0) $display("FAIL burst_bubbles: got %0d expected 0", gaps); else passed++;
        checks++; if (budget != 32) $display("FAIL burst_latency: got %0d cycles expected 32", budget); else passed++;
        tick();
    endtask

    task automatic test_single_port();
        exp_t e;
        int budget = 0;
        do_reset();
        load_a(2, 3);
        for (int k = 0; k < 3; k++) exp_a.push_back(mk(2, k));
        while (exp_a.size() > 0 && budget < 20) begin
            tick();
            budget++;
            if (a_valid) begin
                e = exp_a.pop_front();
                checks++;
                if (a_oport !== e.port || a_odata !== e.data)
                    $display("FAIL single_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
                else passed++;
            end
        end
        checks++; if (exp_a.size() != 0) $display("FAIL single_timeout: %0d words left expected 0", exp_a.size()); else passed++;
        tick();
        checks++; if (a_valid !== 1'b0) $display("FAIL single_drop: got %b expected 0", a_valid); else passed++;
    endtask

    task automatic test_stall();
        exp_t e;
        int budget = 0;
        do_reset();
        out_ready = 1'b0;
        load_a(0, 3);
        load_a(1, 2);
        for (int k = 0; k < 3; k++) exp_a.push_back(mk(0, k));
        for (int k = 0; k < 2; k++) exp_a.push_back(mk(1, k));
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (a_valid !== 1'b1 || a_odata !== wd(0, 0) || a_pop !== '0)
                $display("FAIL stall_hold: got valid %b data %h pop %b expected 1 %h 0", a_valid, a_odata, a_pop, wd(0, 0));
            else passed++;
        end
        checks++; if (qa[0].size() != 2) $display("FAIL stall_no_pop: got %0d expected 2", qa[0].size()); else passed++;
        out_ready = 1'b1;
        e = exp_a.pop_front();
        checks++;
        if (a_oport !== e.port || a_odata !== e.data)
            $display("FAIL stall_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
        else passed++;
        while (exp_a.size() > 0 && budget < 20) begin
            tick();
            budget++;
            if (a_valid) begin
                e = exp_a.pop_front();
                checks++;
                if (a_oport !== e.port || a_odata !== e.data)
                    $display("FAIL stall_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
                else passed++;
            end
        end
        checks++; if (exp_a.size() != 0) $display("FAIL stall_timeout: %0d words left expected 0", exp_a.size()); else passed++;
        tick();
    endtask

    task automatic test_burst_break();
        exp_t e;
        int budget = 0;
        int gaps = 0;
        bit seen = 0;
        do_reset();
        load_a(0, 2);
        load_a(1, 5);
        load_a(3, 3);
        for (int k = 0; k < 2; k++) exp_a.push_back(mk(0, k));
        for (int k = 0; k < 4; k++) exp_a.push_back(mk(1, k));
        for (int k = 0; k < 3; k++) exp_a.push_back(mk(3, k));
        exp_a.push_back(mk(1, 4));
        while (exp_a.size() > 0 && budget < 30) begin
            tick();
            budget++;
            if (a_valid) begin
                seen = 1;
                e = exp_a.pop_front();
                checks++;
                if (a_oport !== e.port || a_odata !== e.data)
                    $display("FAIL break_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
                else passed++;
            end else if (seen) gaps++;
        end
        checks++; if (exp_a.size() != 0) $display("FAIL break_timeout: %0d words left expected 0", exp_a.size()); else passed++;
        checks++; if (gaps != 0) $display("FAIL break_bubbles: got %0d expected 0", gaps); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int budget = 0;
        do_reset();
        load_a(1, 6);
        load_a(2, 2);
        load_a(3, 2);
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (a_valid !== 1'b1 || a_oport !== 2'd1 || a_odata !== wd(1, k))
                $display("FAIL midrst_pre: got valid %b port %0d data %h expected 1 1 %h", a_valid, a_oport, a_odata, wd(1, k));
            else passed++;
        end
        rst = 1'b1;
        qa[0].push_back(wd(0, 0));
        refresh();
        tick();
        rst = 1'b0;
        checks++; if (a_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", a_valid); else passed++;
        checks++; if (qa[1].size() != 4) $display("FAIL midrst_no_pop: got %0d expected 4", qa[1].size()); else passed++;
        exp_a.push_back(mk(0, 0));
        for (int k = 2; k < 6; k++) exp_a.push_back(mk(1, k));
        for (int k = 0; k < 2; k++) exp_a.push_back(mk(2, k));
        for (int k = 0; k < 2; k++) exp_a.push_back(mk(3, k));
        while (exp_a.size() > 0 && budget < 30) begin
            tick();
            budget++;
            if (a_valid) begin
                e = exp_a.pop_front();
                checks++;
                if (a_oport !== e.port || a_odata !== e.data)
                    $display("FAIL midrst_seq: got port %0d data %h expected port %0d data %h", a_oport, a_odata, e.port, e.data);
                else passed++;
            end
        end
        checks++; if (exp_a.size() != 0) $display("FAIL midrst_timeout: %0d words left expected 0", exp_a.size()); else passed++;
        tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int budget = 0;
        int gaps = 0;
        bit seen = 0;
        do_reset();
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 3; k++) qb[p].push_back(wd(p, k));
        refresh();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < N; p++) exp_b.push_back(mk(p, r));
        while (exp_b.size() > 0 && budget < 30) begin
            tick();
            budget++;
            if (b_valid) begin
                seen = 1;
                e = exp_b.pop_front();
                checks++;
                if (b_oport !== e.port || b_odata !== e.data)
                    $display("FAIL rr_seq: got port %0d data %h expected port %0d data %h", b_oport, b_odata, e.port, e.data);
                else passed++;
            end else if (seen) gaps++;
        end
        checks++; if (exp_b.size() != 0) $display("FAIL rr_timeout: %0d words left expected 0", exp_b.size()); else passed++;
        checks++; if (gaps != 0) $display("FAIL rr_bubbles: got %0d expected 0", gaps); else passed++;
        tick();
    endtask

    initial begin
        refresh();
        test_reset();
        test_burst();
        test_single_port();
        test_stall();
        test_burst_break();
        test_reset_mid_burst();
        test_round_robin();
        checks++; if (pop_err != 0) $display("FAIL pop_rules: got %0d violations expected 0", pop_err); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
